// File: rtl/fptd_pkg.sv
// Shared types and helpers for the FPTD termination-gamma datapath.
package fptd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } term_state_e;

  localparam int SCALE_MAX = 4;

  // Clamp a signed value into the range of a signed `width`-bit number.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] res;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) res = hi;
    else if (value < lo) res = lo;
    else res = value;
    return res;
  endfunction

endpackage

// File: rtl/gamma_scale_sat.sv
// Second-stage datapath: divide the k*ba1 product by 4, saturate, add ba2, saturate.
// GAMMA_TERM_ROUND_EN selects round-half-up instead of floor for the divide.
module gamma_scale_sat
  import fptd_pkg::*;
#(
  parameter int M     = 6,
  parameter int N     = 5,
  parameter int OUT_W = M + 1
) (
  input  logic signed [M+2:0]     prod_i,
  input  logic signed [N-1:0]     ba2_i,
  output logic signed [OUT_W-1:0] ba1ba3_o,
  output logic signed [OUT_W-1:0] ba1ba2ba3_o
);

  // One guard bit so the rounding offset cannot wrap the product.
  localparam int PW = M + 4;
  localparam int SW = ((OUT_W > N) ? OUT_W : N) + 1;

  logic signed [PW-1:0] prod_ext;
  logic signed [PW-1:0] scaled;
  logic signed [SW-1:0] a3_ext;
  logic signed [SW-1:0] ba2_ext;
  logic signed [SW-1:0] sum;

  assign prod_ext = {prod_i[M+2], prod_i};

`ifdef GAMMA_TERM_ROUND_EN
  localparam logic signed [PW-1:0] HALF = 2;
  assign scaled = (prod_ext + HALF) >>> 2;
`else
  assign scaled = prod_ext >>> 2;
`endif

  assign ba1ba3_o = OUT_W'(sat_signed({{(32 - PW){scaled[PW-1]}}, scaled}, OUT_W));

  assign a3_ext  = {{(SW - OUT_W){ba1ba3_o[OUT_W-1]}}, ba1ba3_o};
  assign ba2_ext = {{(SW - N){ba2_i[N-1]}}, ba2_i};
  assign sum     = a3_ext + ba2_ext;

  assign ba1ba2ba3_o = OUT_W'(sat_signed({{(32 - SW){sum[SW-1]}}, sum}, OUT_W));

endmodule

// File: rtl/gamma_termination_pipe.sv
// Two-stage termination-gamma pipeline with per-frame tail indexing and valid/ready on both sides.
// Optional macro GAMMA_TERM_ROUND_EN switches the k/4 scaling from floor to round-half-up.
module gamma_termination_pipe
  import fptd_pkg::*;
#(
  parameter int M        = 6,
  parameter int N        = 5,
  parameter int OUT_W    = M + 1,
  parameter int NUM_TERM = 3,
  parameter int IDX_W    = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              scale_k,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [M-1:0]            ba1,
  input  logic [N-1:0]            ba2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [IDX_W-1:0]        out_idx,
  output logic [OUT_W-1:0]        ba1ba3,
  output logic [OUT_W-1:0]        ba1ba2ba3,
  output logic                    frame_err,
  output logic                    dbg_state
);

  // Handshake: a beat moves on a side when valid and ready are both high at the
  // rising edge; valid holds its payload stable until taken, ready may depend on
  // downstream ready (in_ready is combinational from out_ready through the stall chain).

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TERM - 1);

  term_state_e      state_q;
  logic [IDX_W-1:0] idx_q;
  logic [2:0]       k_q;

  logic             en1;
  logic             en2;
  logic             in_fire;
  logic [2:0]       k_new;
  logic [2:0]       k_beat;
  logic             at_end;
  logic             beat_last;
  logic             beat_err;
  logic signed [M+2:0] prod_d;

  logic                    s1_valid_q;
  logic signed [M+2:0]     s1_prod_q;
  logic signed [N-1:0]     s1_ba2_q;
  logic                    s1_last_q;
  logic                    s1_err_q;
  logic [IDX_W-1:0]        s1_idx_q;

  logic                    out_valid_q;
  logic                    out_last_q;
  logic                    frame_err_q;
  logic [IDX_W-1:0]        out_idx_q;
  logic signed [OUT_W-1:0] ba1ba3_q;
  logic signed [OUT_W-1:0] ba1ba2ba3_q;
  logic signed [OUT_W-1:0] s2_a3;
  logic signed [OUT_W-1:0] s2_a23;

  assign en2      = !out_valid_q | out_ready;
  assign en1      = !s1_valid_q | en2;
  assign in_ready = en1;
  assign in_fire  = in_valid & en1;

  // The first beat of a frame already uses the scale it latches.
  assign k_new     = (scale_k > 3'(SCALE_MAX)) ? 3'(SCALE_MAX) : scale_k;
  assign k_beat    = (state_q == IDLE) ? k_new : k_q;
  assign at_end    = (idx_q == LAST_IDX);
  assign beat_last = in_last | at_end;
  assign beat_err  = in_last ^ at_end;
  assign prod_d    = $signed({{M{1'b0}}, k_beat}) * $signed({{3{ba1[M-1]}}, ba1});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      k_q     <= '0;
    end else if (in_fire) begin
      if (state_q == IDLE) k_q <= k_new;
      if (beat_last) begin
        state_q <= IDLE;
        idx_q   <= '0;
      end else begin
        state_q <= RUN;
        idx_q   <= idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_ba2_q   <= '0;
      s1_last_q  <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_idx_q   <= '0;
    end else if (en1) begin
      s1_valid_q <= in_fire;
      if (in_fire) begin
        s1_prod_q <= prod_d;
        s1_ba2_q  <= ba2;
        s1_last_q <= beat_last;
        s1_err_q  <= beat_err;
        s1_idx_q  <= idx_q;
      end
    end
  end

  gamma_scale_sat #(
    .M    (M),
    .N    (N),
    .OUT_W(OUT_W)
  ) u_scale_sat (
    .prod_i     (s1_prod_q),
    .ba2_i      (s1_ba2_q),
    .ba1ba3_o   (s2_a3),
    .ba1ba2ba3_o(s2_a23)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
      out_idx_q   <= '0;
      ba1ba3_q    <= '0;
      ba1ba2ba3_q <= '0;
    end else if (en2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_last_q  <= s1_last_q;
        frame_err_q <= s1_err_q;
        out_idx_q   <= s1_idx_q;
        ba1ba3_q    <= s2_a3;
        ba1ba2ba3_q <= s2_a23;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign frame_err = frame_err_q;
  assign out_idx   = out_idx_q;
  assign ba1ba3    = ba1ba3_q;
  assign ba1ba2ba3 = ba1ba2ba3_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gamma_termination_pipe.sv
// Scoreboard bench for gamma_termination_pipe: a default-width instance plus an OUT_W=6
// instance fed identical traffic so saturation of both outputs is exercised.
module tb_gamma_termination_pipe;

  localparam int M        = 6;
  localparam int N        = 5;
  localparam int OUT_W    = 7;
  localparam int OUT_W_B  = 6;
  localparam int NUM_TERM = 3;
  localparam int IDX_W    = 2;
  localparam int EXP_W    = 2 * OUT_W + 2 * OUT_W_B + 2 + IDX_W;

  logic             clk;
  logic             rst;
  logic [2:0]       scale_k;
  logic             in_valid;
  logic             in_last;
  logic [M-1:0]     ba1;
  logic [N-1:0]     ba2;
  logic             out_ready;

  logic             in_ready, out_valid, out_last, frame_err, dbg_state;
  logic [IDX_W-1:0] out_idx;
  logic [OUT_W-1:0] ba1ba3, ba1ba2ba3;

  logic               in_ready_b, out_valid_b, out_last_b, frame_err_b, dbg_state_b;
  logic [IDX_W-1:0]   out_idx_b;
  logic [OUT_W_B-1:0] ba1ba3_b, ba1ba2ba3_b;

  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit rnd_ready = 0;

  bit m_run = 0;
  int m_idx = 0;
  int m_k   = 0;

  gamma_termination_pipe #(.M(M), .N(N), .OUT_W(OUT_W), .NUM_TERM(NUM_TERM)) dut (
    .clk(clk), .rst(rst), .scale_k(scale_k), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .ba1(ba1), .ba2(ba2), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_idx(out_idx), .ba1ba3(ba1ba3), .ba1ba2ba3(ba1ba2ba3),
    .frame_err(frame_err), .dbg_state(dbg_state)
  );

  gamma_termination_pipe #(.M(M), .N(N), .OUT_W(OUT_W_B), .NUM_TERM(NUM_TERM)) dut_b (
    .clk(clk), .rst(rst), .scale_k(scale_k), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_last(in_last), .ba1(ba1), .ba2(ba2), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_last(out_last_b), .out_idx(out_idx_b), .ba1ba3(ba1ba3_b), .ba1ba2ba3(ba1ba2ba3_b),
    .frame_err(frame_err_b), .dbg_state(dbg_state_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int sat_int(input int v, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic int model_a3(input int k, input int b1, input int w);
    int p;
    p = k * b1;
`ifdef GAMMA_TERM_ROUND_EN
    return sat_int((p + 2) >>> 2, w);
`else
    return sat_int(p >>> 2, w);
`endif
  endfunction

  task automatic model_push(input int k_in, input int b1, input int b2, input bit last);
    int idx;
    bit at_end, blast, berr;
    logic [31:0] a3, a23, b3, b23, idx_v;
    if (!m_run) m_k = (k_in > 4) ? 4 : k_in;
    idx    = m_run ? m_idx : 0;
    at_end = (idx == NUM_TERM - 1);
    blast  = last || at_end;
    berr   = (last != at_end);
    a3  = model_a3(m_k, b1, OUT_W);
    a23 = sat_int(int'(a3) + b2, OUT_W);
    b3  = model_a3(m_k, b1, OUT_W_B);
    b23 = sat_int(int'(b3) + b2, OUT_W_B);
    idx_v = idx;
    exp_q.push_back({a3[OUT_W-1:0], a23[OUT_W-1:0], b3[OUT_W_B-1:0], b23[OUT_W_B-1:0],
                     blast, berr, idx_v[IDX_W-1:0]});
    if (blast) begin
      m_run = 0;
      m_idx = 0;
    end else begin
      m_run = 1;
      m_idx = idx + 1;
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] exp_v, got_v;
    if (!rst && out_valid && out_ready) begin
      got_v = {ba1ba3, ba1ba2ba3, ba1ba3_b, ba1ba2ba3_b, out_last, frame_err, out_idx};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got beat %h, expected no beat", got_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v[EXP_W-1:IDX_W+2] !== exp_v[EXP_W-1:IDX_W+2]) begin
          n_fail++;
          $display("FAIL beat_data: got %h expected %h", got_v[EXP_W-1:IDX_W+2],
                   exp_v[EXP_W-1:IDX_W+2]);
        end
        n_checks++;
        if (got_v[IDX_W+1:0] !== exp_v[IDX_W+1:0]) begin
          n_fail++;
          $display("FAIL beat_ctrl(last,err,idx): got %b expected %b", got_v[IDX_W+1:0],
                   exp_v[IDX_W+1:0]);
        end
      end
      n_checks++;
      if ({out_valid_b, out_last_b, frame_err_b, out_idx_b} !== {1'b1, out_last, frame_err, out_idx}) begin
        n_fail++;
        $display("FAIL narrow_ctrl: got %b expected %b", {out_valid_b, out_last_b, frame_err_b, out_idx_b},
                 {1'b1, out_last, frame_err, out_idx});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_beat(input int k, input int b1, input int b2, input bit last);
    bit acc;
    int budget;
    logic [31:0] kv, b1v, b2v;
    kv = k; b1v = b1; b2v = b2;
    scale_k  = kv[2:0];
    ba1      = b1v[M-1:0];
    ba2      = b2v[N-1:0];
    in_last  = last;
    in_valid = 1'b1;
    acc = 0;
    budget = 0;
    while (!acc) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready;
      if (acc) model_push(k, b1, b2, last);
      @(posedge clk);
      #1;
      budget++;
      if (!acc && budget > 1000) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: got no in_ready in %0d cycles, expected acceptance", budget);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    in_valid = 1'b0;
    while (exp_q.size() > 0 && budget < 2000) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      budget++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d beats outstanding, expected 0", exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; scale_k = '0; ba1 = '0; ba2 = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid_in_reset: got %b expected 0", out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if ({out_last, frame_err, out_idx} !== '0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {out_last, frame_err, out_idx});
    end
    n_checks++;
    if ({ba1ba3, ba1ba2ba3} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {ba1ba3, ba1ba2ba3});
    end
    n_checks++;
    if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b expected 0 (IDLE)", dbg_state); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    rnd_ready = 0; out_ready = 1'b1;
    send_beat(3, -32, -16, 1'b1);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: got out_valid %b expected 0", out_valid); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %b expected 1", out_valid); end
    n_checks++;
    if ($signed(ba1ba3) !== -24) begin n_fail++; $display("FAIL latency_ba1ba3: got %0d expected -24", $signed(ba1ba3)); end
    n_checks++;
    if ($signed(ba1ba2ba3) !== -40) begin
      n_fail++; $display("FAIL latency_ba1ba2ba3: got %0d expected -40", $signed(ba1ba2ba3));
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_rounding();
    int exp_pos;
`ifdef GAMMA_TERM_ROUND_EN
    exp_pos = 4;
`else
    exp_pos = 3;
`endif
    rnd_ready = 0; out_ready = 1'b1;
    send_beat(3, 5, 0, 1'b0);
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ($signed(ba1ba3) !== exp_pos) begin
      n_fail++; $display("FAIL round_pos: got %0d expected %0d", $signed(ba1ba3), exp_pos);
    end
    @(posedge clk); #1;
    send_beat(3, -5, 0, 1'b1);
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ($signed(ba1ba3) !== -4) begin n_fail++; $display("FAIL round_neg: got %0d expected -4", $signed(ba1ba3)); end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_saturation();
    rnd_ready = 0; out_ready = 1'b1;
    send_beat(4, 31, 15, 1'b0);
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({$signed(ba1ba3_b), $signed(ba1ba2ba3_b)} !== {6'sd31, 6'sd31}) begin
      n_fail++; $display("FAIL sat_high: got %0d/%0d expected 31/31", $signed(ba1ba3_b), $signed(ba1ba2ba3_b));
    end
    n_checks++;
    if ($signed(ba1ba2ba3) !== 46) begin n_fail++; $display("FAIL wide_high: got %0d expected 46", $signed(ba1ba2ba3)); end
    @(posedge clk); #1;
    send_beat(7, -32, -16, 1'b1);
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({$signed(ba1ba3_b), $signed(ba1ba2ba3_b)} !== {-6'sd32, -6'sd32}) begin
      n_fail++; $display("FAIL sat_low: got %0d/%0d expected -32/-32", $signed(ba1ba3_b), $signed(ba1ba2ba3_b));
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_frames();
    rnd_ready = 0; out_ready = 1'b1;
    // Well-formed frame, then scale changes on later beats that must be ignored.
    send_beat(1, 20, 1, 1'b0);
    send_beat(4, 21, 2, 1'b0);
    send_beat(0, 22, 3, 1'b1);
    // Early end on idx 1, then next frame restarts at idx 0.
    send_beat(2, -9, -3, 1'b0);
    send_beat(2, -10, 4, 1'b1);
    idle(1);
    n_checks++;
    if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL early_end_state: got %b expected 0 (IDLE)", dbg_state); end
    // Missing in_last: implicit end on idx 2.
    send_beat(3, 7, -1, 1'b0);
    send_beat(3, 8, -2, 1'b0);
    send_beat(3, 9, -3, 1'b0);
    send_beat(4, 10, 5, 1'b0);
    send_beat(4, 11, 5, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back_random();
    int len;
    bit last;
    rnd_ready = 1;
    for (int f = 0; f < 100; f++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        last = (b == len - 1) && ($urandom_range(0, 4) != 0);
        send_beat($urandom_range(0, 7), int'($urandom_range(0, 63)) - 32,
                  int'($urandom_range(0, 31)) - 16, last);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();
    rnd_ready = 0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    rnd_ready = 0; out_ready = 1'b0;
    send_beat(2, 10, 3, 1'b0);
    send_beat(2, 11, 3, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    m_run = 0; m_idx = 0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", out_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_valid[%0d]: got %b expected 0", i, out_valid);
      end
    end
    @(posedge clk); #1;
    send_beat(1, 12, 0, 1'b0);
    send_beat(1, 13, 0, 1'b0);
    send_beat(1, 14, 0, 1'b1);
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_saturation();
    test_frames();
    test_back_to_back_random();
    test_reset_mid_frame();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL final_queue: got %0d beats left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
